// File: rtl/orbit_pkg.sv
// rtl/orbit_pkg.sv - shared orbit phase constants, FSM states and CORDIC arctangent table
package orbit_pkg;

    localparam int ANGLE_W = 8;
    localparam int PHASE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // atan(2^-i) in 1/65536-turn units
    function automatic logic [PHASE_W-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'd8192;
            4'd1:    atan_lut = 16'd4836;
            4'd2:    atan_lut = 16'd2555;
            4'd3:    atan_lut = 16'd1297;
            4'd4:    atan_lut = 16'd651;
            4'd5:    atan_lut = 16'd326;
            4'd6:    atan_lut = 16'd163;
            4'd7:    atan_lut = 16'd81;
            4'd8:    atan_lut = 16'd41;
            4'd9:    atan_lut = 16'd20;
            4'd10:   atan_lut = 16'd10;
            4'd11:   atan_lut = 16'd5;
            4'd12:   atan_lut = 16'd3;
            4'd13:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/xy_to_angle_if.sv
// rtl/xy_to_angle_if.sv - valid/ready request and result channels of the vectoring unit
interface xy_to_angle_if
    import orbit_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [ANGLE_W-1:0]       angle_out;
    logic [DATA_W:0]          mag_out;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, angle_out, mag_out
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, angle_out, mag_out
    );
endinterface

// File: rtl/xy_to_angle.sv
// rtl/xy_to_angle.sv - iterative CORDIC vectoring: (x, y) to 8-bit phase index and scaled magnitude
module xy_to_angle
    import orbit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ITER   = 12
) (
    input logic           clk,
    input logic           reset,
    xy_to_angle_if.slave  bus
);
    localparam int         W2   = DATA_W + 2;
    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_e                state;
    logic signed [W2-1:0]  x_r, y_r, x_n, y_n, x_ext, y_ext;
    logic [PHASE_W-1:0]    z_r, z_n;
    logic [3:0]            iter;
    logic                  zero_r;
    logic                  out_valid_r;
    logic [ANGLE_W-1:0]    angle_r, angle_n;
    logic [DATA_W:0]       mag_r;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.angle_out = angle_r;
    assign bus.mag_out   = mag_r;

    // Two guard bits let -(-2^(DATA_W-1)) and the CORDIC gain growth fit without overflow
    assign x_ext = {{2{bus.x_in[DATA_W-1]}}, bus.x_in};
    assign y_ext = {{2{bus.y_in[DATA_W-1]}}, bus.y_in};

    always_comb begin
        x_n = x_r;
        y_n = y_r;
        z_n = z_r;
        if (!y_r[W2-1]) begin
            x_n = x_r + (y_r >>> iter);
            y_n = y_r - (x_r >>> iter);
            z_n = z_r + atan_lut(iter);
        end else begin
            x_n = x_r - (y_r >>> iter);
            y_n = y_r + (x_r >>> iter);
            z_n = z_r - atan_lut(iter);
        end
        // Round to nearest phase step; wraps 0xFF80.. to 8'h00
        angle_n = z_n[PHASE_W-1:PHASE_W-ANGLE_W] + {7'd0, z_n[PHASE_W-ANGLE_W-1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            iter        <= '0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            angle_r     <= '0;
            mag_r       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (x_ext[W2-1]) begin
                            x_r <= -x_ext;
                            y_r <= -y_ext;
                            z_r <= 16'h8000;
                        end else begin
                            x_r <= x_ext;
                            y_r <= y_ext;
                            z_r <= '0;
                        end
                        zero_r <= (bus.x_in == '0) && (bus.y_in == '0);
                        iter   <= '0;
                        state  <= ST_ROTATE;
                    end
                end
                ST_ROTATE: begin
                    x_r  <= x_n;
                    y_r  <= y_n;
                    z_r  <= z_n;
                    iter <= iter + 4'd1;
                    if (iter == LAST) begin
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                        angle_r     <= zero_r ? '0 : angle_n;
                        mag_r       <= zero_r ? '0 : x_n[DATA_W:0];
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xy_to_angle.sv
// tb/tb_xy_to_angle.sv - self-checking bench for xy_to_angle
module tb_xy_to_angle;
    localparam int  DATA_W = 16;
    localparam int  ITER   = 12;
    localparam real PI     = 3.14159265358979;
    localparam real GAIN   = 1.6467602;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xy_to_angle_if #(.DATA_W(DATA_W)) bus ();
    xy_to_angle #(.DATA_W(DATA_W), .ITER(ITER)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int x;
        int y;
        int ang;
        int mag;
        int mag_tol;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic real circ_dist(input real a, input real b);
        real d;
        d = a - b;
        while (d >= 128.0) d -= 256.0;
        while (d < -128.0) d += 256.0;
        return (d < 0.0) ? -d : d;
    endfunction

    function automatic real ref_angle(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * 256.0 / (2.0 * PI);
        if (a < 0.0) a += 256.0;
        return a;
    endfunction

    function automatic real ref_mag(input int x, input int y);
        return GAIN * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    endfunction

    function automatic int rnd(input real r);
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    endfunction

    task automatic chk_ang(input string name, input int act, input real exp, input real tol);
        tests++;
        if (circ_dist(real'(act), exp) > tol) begin
            fails++;
            $display("FAIL %s: got angle %0d expected %f +-%f", name, act, exp, tol);
        end
    endtask

    task automatic chk_mag(input string name, input int act, input real exp, input real tol);
        real d;
        d = real'(act) - exp;
        tests++;
        if (d > tol || d < -tol) begin
            fails++;
            $display("FAIL %s: got mag %0d expected %f +-%f", name, act, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, output int ang, output int mag);
        int n = 0;
        int lat;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        bus.x_in     = 16'(x);
        bus.y_in     = 16'(y);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            step();
            lat++;
        end
        chk("latency", lat, ITER + 1);
        ang = int'(bus.angle_out);
        mag = int'(bus.mag_out);
    endtask

    initial begin
        int ang, mag, a0, m0, n, x, y, ok;
        int t[3];
        int ra[3];

        tbl[0] = '{16384, 0, 8'h00, 26981, 8};
        tbl[1] = '{0, 16384, 8'h40, -1, 0};
        tbl[2] = '{-16384, 0, 8'h80, -1, 0};
        tbl[3] = '{0, -16384, 8'hC0, -1, 0};
        tbl[4] = '{11585, 11585, 8'h20, 26981, 8};
        tbl[5] = '{-32768, 0, 8'h80, -1, 0};
        tbl[6] = '{0, 0, 8'h00, 0, 0};

        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_angle", bus.angle_out, 0);
        chk("reset_mag", bus.mag_out, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].x, tbl[i].y, ang, mag);
            chk($sformatf("table%0d_angle", i), ang, tbl[i].ang);
            if (tbl[i].mag >= 0)
                chk_mag($sformatf("table%0d_mag", i), mag, real'(tbl[i].mag), real'(tbl[i].mag_tol));
        end

        for (int i = 0; i < 40; i++) begin
            do begin
                x = int'($urandom_range(65535)) - 32768;
                y = int'($urandom_range(65535)) - 32768;
            end while (ref_mag(x, y) < 4096.0 * GAIN);
            send(x, y, ang, mag);
            chk_ang($sformatf("rand%0d_angle(%0d,%0d)", i, x, y), ang, ref_angle(x, y), 0.75);
            chk_mag($sformatf("rand%0d_mag(%0d,%0d)", i, x, y), mag, ref_mag(x, y),
                    16.0 + 0.002 * ref_mag(x, y));
        end

        for (int k = 0; k < 256; k++) begin
            x = rnd(32767.0 * $sin(2.0 * PI * real'((k + 64) % 256) / 256.0));
            y = rnd(32767.0 * $sin(2.0 * PI * real'(k) / 256.0));
            send(x, y, ang, mag);
            chk_ang($sformatf("sweep_k%0d", k), ang, real'(k), 1.0);
        end

        // Backpressure: result must hold while a stray request is ignored
        step();
        bus.out_ready = 1'b0;
        send(16384, 0, a0, m0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.x_in     = 16'd0;
                bus.y_in     = 16'd16384;
                bus.in_valid = 1'b1;
            end
            if (i == 7) bus.in_valid = 1'b0;
            step();
            chk($sformatf("bp%0d_out_valid", i), bus.out_valid, 1);
            chk($sformatf("bp%0d_in_ready", i), bus.in_ready, 0);
            chk($sformatf("bp%0d_angle", i), bus.angle_out, a0);
            chk($sformatf("bp%0d_mag", i), bus.mag_out, m0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid) ok = 0;
        end
        chk("bp_stray_not_accepted", ok, 1);

        // Back-to-back stream with in_valid held high
        fork
            begin
                bus.in_valid = 1'b1;
                for (int v = 0; v < 3; v++) begin
                    bus.x_in = 16'(tbl[v].x);
                    bus.y_in = 16'(tbl[v].y);
                    n = 0;
                    while (!bus.in_ready && n < 100) begin
                        step();
                        n++;
                    end
                    step();
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int r = 0; r < 3; r++) begin
                    n = 0;
                    while (!bus.out_valid && n < 100) begin
                        step();
                        n++;
                    end
                    t[r]  = cyc;
                    ra[r] = int'(bus.angle_out);
                    step();
                end
            end
        join
        for (int r = 0; r < 3; r++) chk($sformatf("b2b%0d_angle", r), ra[r], tbl[r].ang);
        chk("b2b_spacing01", t[1] - t[0], ITER + 2);
        chk("b2b_spacing12", t[2] - t[1], ITER + 2);

        // Reset during ROTATE discards the computation
        step();
        bus.x_in     = 16'd16384;
        bus.y_in     = 16'd0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("rst_mid_in_ready", bus.in_ready, 1);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        step();
        reset = 1'b0;
        chk("rst_mid_angle", bus.angle_out, 0);
        chk("rst_mid_mag", bus.mag_out, 0);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid || !bus.in_ready) ok = 0;
        end
        chk("rst_mid_quiet", ok, 1);
        send(0, 16384, ang, mag);
        chk("rst_after_angle", ang, 8'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
